// File: rtl/nonce_search_ctrl_if.sv
// nonce_search_ctrl_if: control, verdict and status signals between search controller and its neighbours
interface nonce_search_ctrl_if #(parameter int NONCE_W = 32);
  logic               start;
  logic               abort;
  logic [NONCE_W-1:0] start_nonce;
  logic               valid;
  logic               next;
  logic               hash_start;
  logic [NONCE_W-1:0] nonce;
  logic               busy;
  logic               done;
  logic               found;
  logic               exhausted;
  logic               timeout;
  logic [NONCE_W-1:0] nonce_found;
  logic [NONCE_W-1:0] tries;
  modport master (
    output start, abort, start_nonce, valid, next,
    input  hash_start, nonce, busy, done, found, exhausted, timeout, nonce_found, tries
  );
  modport slave (
    input  start, abort, start_nonce, valid, next,
    output hash_start, nonce, busy, done, found, exhausted, timeout, nonce_found, tries
  );
endinterface

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: launches nonces at the hash core and steps through them until a verdict ends the search
module nonce_search_ctrl #(
  parameter int                   NONCE_W   = 32,
  parameter logic [NONCE_W-1:0]   MAX_NONCE = {NONCE_W{1'b1}},
  parameter int                   TIMEOUT   = 64
) (
  input logic                 clk,
  input logic                 reset,
  nonce_search_ctrl_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic               r_hash_start, r_busy, r_done, r_found, r_exhausted, r_timeout;
  logic [NONCE_W-1:0] r_nonce, r_nonce_found, r_tries;
  assign bus.hash_start  = r_hash_start;
  assign bus.nonce       = r_nonce;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.found       = r_found;
  assign bus.exhausted   = r_exhausted;
  assign bus.timeout     = r_timeout;
  assign bus.nonce_found = r_nonce_found;
  assign bus.tries       = r_tries;
  // Outputs are set on the edge entering each state so they line up with it
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_hash_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_timeout     <= 1'b0;
      r_nonce       <= '0;
      r_nonce_found <= '0;
      r_tries       <= '0;
    end else begin
      r_hash_start <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_nonce       <= bus.start_nonce;
          r_found       <= 1'b0;
          r_exhausted   <= 1'b0;
          r_timeout     <= 1'b0;
          r_nonce_found <= '0;
          r_tries       <= '0;
          r_busy        <= 1'b1;
          r_hash_start  <= 1'b1;
          r_state       <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_tries <= r_tries + 1'b1;
          r_timer <= '0;
          r_busy  <= !bus.abort;
          r_state <= bus.abort ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus.valid) begin
            r_found       <= 1'b1;
            r_nonce_found <= r_nonce;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else if (bus.next && r_nonce == MAX_NONCE) begin
            r_exhausted <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (bus.next) begin
            r_nonce      <= r_nonce + 1'b1;
            r_hash_start <= 1'b1;
            r_state      <= S_LAUNCH;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
